// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Data-memory bus between the memory-stage controller and the data memory.
//   mem_req   : access request (controller -> memory)
//   mem_wr    : 1 = write, 0 = read, meaningful while mem_req
//   mem_addr  : access address
//   mem_wdata : store data
//   mem_dump  : one-cycle dump pulse
//   mem_ready : memory completes the access this cycle (memory -> controller)
//   mem_rdata : read data, valid when mem_ready
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_dump;
  logic        mem_ready;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller between the EX/MEM latch and writeback. Issues data
// memory accesses over a req/ready handshake, stalls the upstream pipeline while
// an access is outstanding, flags a sticky error when the memory does not answer
// within MAX_WAIT cycles, and registers the MEM/WB pipeline outputs.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   *_in                : EX/MEM control and data (held stable by upstream stall)
//   mem                 : data memory bus (master side)
//   stall_out           : freezes PC, IF/ID, ID/EX, EX/MEM
//   err                 : sticky timeout error, cleared only by reset
//   *_out               : MEM/WB pipeline register outputs
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWrite_in,
  input  logic                   MemToReg_in,
  input  logic                   DMemEn_in,
  input  logic                   DMemWrite_in,
  input  logic                   DMemDump_in,
  input  logic [2:0]             WriteRegister_in,
  input  logic [15:0]            aluOutput_in,
  input  logic [15:0]            B_in,
  mem_stage_ctrl_if.master       mem,
  output logic                   stall_out,
  output logic                   err,
  output logic                   RegWrite_out,
  output logic                   MemToReg_out,
  output logic                   halt_out,
  output logic [2:0]             WriteRegister_out,
  output logic [15:0]            aluOutput_out,
  output logic [15:0]            memData_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        halt_q, halt_d;
  logic [2:0]  wreg_q, wreg_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] mdata_q, mdata_d;

  logic        mem_op;
  logic        dump_op;
  logic        req;
  logic        wr;
  logic        rd_done;
  logic [3:0]  wait_inc;

  assign mem_op   = DMemEn_in & ~DMemDump_in;
  assign dump_op  = DMemEn_in & DMemDump_in;
  assign req      = rst & (((state_q == ST_IDLE) & mem_op) | (state_q == ST_BUSY));
  assign wr       = req & DMemWrite_in;
  assign rd_done  = req & ~wr & mem.mem_ready;
  // wait_cnt holds the number of not-ready cycles already seen; the current
  // cycle is therefore number wait_cnt+1 of the access.
  assign wait_inc = wait_cnt_q + 4'd1;

  assign mem.mem_req   = req;
  assign mem.mem_wr    = wr;
  assign mem.mem_addr  = aluOutput_in;
  assign mem.mem_wdata = B_in;
  assign mem.mem_dump  = rst & (state_q == ST_IDLE) & dump_op;
  assign stall_out     = rst & ((req & ~mem.mem_ready) | (state_q == ST_ERR));

  assign err               = err_q;
  assign RegWrite_out      = regwrite_q;
  assign MemToReg_out      = memtoreg_q;
  assign halt_out          = halt_q;
  assign WriteRegister_out = wreg_q;
  assign aluOutput_out     = alu_q;
  assign memData_out       = mdata_q;

  // Access FSM and wait counter next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op & ~mem.mem_ready) begin
          // First not-ready cycle may already exhaust a MAX_WAIT of 1.
          if (MAX_WAIT_C == 4'd1) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_BUSY;
          end
          wait_cnt_d = 4'd1;
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      ST_BUSY: begin
        if (mem.mem_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_inc == MAX_WAIT_C) begin
          state_d    = ST_ERR;
          wait_cnt_d = wait_inc;
        end else begin
          state_d    = ST_BUSY;
          wait_cnt_d = wait_inc;
        end
      end
      ST_ERR: begin
        state_d    = ST_ERR;
        wait_cnt_d = wait_cnt_q;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    err_d = (state_d == ST_ERR);
  end

  // MEM/WB register next-state: bubble on stall, data fields hold
  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    halt_d     = halt_q;
    wreg_d     = wreg_q;
    alu_d      = alu_q;
    mdata_d    = mdata_q;
    if (stall_out) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      halt_d     = 1'b0;
    end else begin
      regwrite_d = RegWrite_in;
      memtoreg_d = MemToReg_in;
      halt_d     = dump_op;
      wreg_d     = WriteRegister_in;
      alu_d      = aluOutput_in;
    end
    if (rd_done) begin
      mdata_d = mem.mem_rdata;
    end else begin
      mdata_d = mdata_q;
    end
  end

  // State, counter, error and MEM/WB flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      halt_q     <= 1'b0;
      wreg_q     <= 3'd0;
      alu_q      <= 16'd0;
      mdata_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      halt_q     <= halt_d;
      wreg_q     <= wreg_d;
      alu_q      <= alu_d;
      mdata_q    <= mdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed-vector bench. A driver applies one vector per cycle just after the
// rising edge and pushes the hand-computed expected outputs for that cycle into
// a scoreboard queue; a monitor pops one entry per falling edge and compares.
// Each entry holds the expected combinational outputs for the current inputs
// and the MEM/WB/err values produced by the previous rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  typedef struct {
    logic        rst, en, wr, dmp, rw, m2r;
    logic [2:0]  wreg;
    logic [15:0] alu, b;
    logic        rdy;
    logic [15:0] rdata;
  } stim_t;

  typedef struct {
    logic        chk;
    logic        req, mwr, mdump, stall, er, rw, m2r, halt;
    logic [2:0]  wreg;
    logic [15:0] alu, mdata, addr, wdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        RegWrite_in, MemToReg_in, DMemEn_in, DMemWrite_in, DMemDump_in;
  logic [2:0]  WriteRegister_in;
  logic [15:0] aluOutput_in, B_in;
  logic        stall_out, err, RegWrite_out, MemToReg_out, halt_out;
  logic [2:0]  WriteRegister_out;
  logic [15:0] aluOutput_out, memData_out;

  mem_stage_ctrl_if mif();

  mem_stage_ctrl #(.MAX_WAIT(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .RegWrite_in       (RegWrite_in),
    .MemToReg_in       (MemToReg_in),
    .DMemEn_in         (DMemEn_in),
    .DMemWrite_in      (DMemWrite_in),
    .DMemDump_in       (DMemDump_in),
    .WriteRegister_in  (WriteRegister_in),
    .aluOutput_in      (aluOutput_in),
    .B_in              (B_in),
    .mem               (mif),
    .stall_out         (stall_out),
    .err               (err),
    .RegWrite_out      (RegWrite_out),
    .MemToReg_out      (MemToReg_out),
    .halt_out          (halt_out),
    .WriteRegister_out (WriteRegister_out),
    .aluOutput_out     (aluOutput_out),
    .memData_out       (memData_out)
  );

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_miss = 0;
  int   n_mon  = 0;

  // Clock starts high so the first falling edge samples vector 0.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(input logic r, en, wr, dmp, rw, m2r,
                               input logic [2:0] wreg, input logic [15:0] alu, b,
                               input logic rdy, input logic [15:0] rdata);
    stim_t s;
    s.rst = r; s.en = en; s.wr = wr; s.dmp = dmp; s.rw = rw; s.m2r = m2r;
    s.wreg = wreg; s.alu = alu; s.b = b; s.rdy = rdy; s.rdata = rdata;
    return s;
  endfunction

  function automatic exp_t ex(input logic chk, req, mwr, mdump, stall, er, rw, m2r, halt,
                              input logic [2:0] wreg, input logic [15:0] alu, mdata);
    exp_t e;
    e.chk = chk; e.req = req; e.mwr = mwr; e.mdump = mdump; e.stall = stall; e.er = er;
    e.rw = rw; e.m2r = m2r; e.halt = halt; e.wreg = wreg; e.alu = alu; e.mdata = mdata;
    e.addr = 16'h0; e.wdata = 16'h0;
    return e;
  endfunction

  task automatic step(input stim_t s, input exp_t e);
    rst              = s.rst;
    DMemEn_in        = s.en;
    DMemWrite_in     = s.wr;
    DMemDump_in      = s.dmp;
    RegWrite_in      = s.rw;
    MemToReg_in      = s.m2r;
    WriteRegister_in = s.wreg;
    aluOutput_in     = s.alu;
    B_in             = s.b;
    mif.mem_ready    = s.rdy;
    mif.mem_rdata    = s.rdata;
    e.addr  = s.alu;
    e.wdata = s.b;
    exp_q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, nm, act, want);
    end
  endtask

  // Scoreboard monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem_req",   n_mon, 16'(mif.mem_req),  16'(e.req));
      chk("mem_wr",    n_mon, 16'(mif.mem_wr),   16'(e.mwr));
      chk("mem_dump",  n_mon, 16'(mif.mem_dump), 16'(e.mdump));
      chk("stall_out", n_mon, 16'(stall_out),    16'(e.stall));
      if (e.req) begin
        chk("mem_addr",  n_mon, mif.mem_addr,  e.addr);
        chk("mem_wdata", n_mon, mif.mem_wdata, e.wdata);
      end
      if (e.chk) begin
        chk("err",          n_mon, 16'(err),               16'(e.er));
        chk("RegWrite_out", n_mon, 16'(RegWrite_out),      16'(e.rw));
        chk("MemToReg_out", n_mon, 16'(MemToReg_out),      16'(e.m2r));
        chk("halt_out",     n_mon, 16'(halt_out),          16'(e.halt));
        chk("WriteReg_out", n_mon, 16'(WriteRegister_out), 16'(e.wreg));
        chk("aluOutput_out",n_mon, aluOutput_out,          e.alu);
        chk("memData_out",  n_mon, memData_out,            e.mdata);
      end
      n_mon++;
    end
  end

  initial begin
    stim_t s, nop, ld;
    exp_t  wait_e;
    nop = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    // Reset with random inputs, two cycles
    for (int i = 0; i < 2; i++) begin
      s = mk(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      step(s, ex((i == 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    end

    // ALU op passes through with one cycle of latency
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h1234, 16'h0000, 1'b0, 16'h0000),
         ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    step(nop, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h1234, 16'h0000));

    // Load 0x0040 with three wait cycles, then 0xBEEF
    ld = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h0040, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++)
      step(ld, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    ld.rdy = 1'b1; ld.rdata = 16'hBEEF;
    step(ld, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));

    // Zero-wait store (rdata junk must be ignored), then back-to-back load
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0010, 16'hA5A5, 1'b1, 16'hFFFF),
         ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0040, 16'hBEEF));
    step(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0020, 16'h0000, 1'b1, 16'h1357),
         ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0010, 16'hBEEF));

    // Dump with a stray mem_ready that must be ignored
    step(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF),
         ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 16'h0020, 16'h1357));
    step(nop, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h1357));

    // Load whose ready arrives in the 8th cycle: completion, not error
    ld = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0080, 16'h0000, 1'b0, 16'h0000);
    wait_e = ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1357);
    for (int i = 0; i < 7; i++) step(ld, wait_e);
    ld.rdy = 1'b1; ld.rdata = 16'h2468;
    step(ld, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h1357));
    step(nop, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0080, 16'h2468));

    // Reset in the second wait cycle of a load
    ld = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0100, 16'h0000, 1'b0, 16'h0000);
    step(ld, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h2468));
    ld.rst = 1'b0; ld.rdy = 1'b1; ld.rdata = 16'hDEAD;
    step(ld, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h2468));
    step(nop, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));

    // Timeout: eight not-ready cycles, then ERR holds until reset
    ld = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0200, 16'h0000, 1'b0, 16'h0000);
    wait_e = ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) step(ld, wait_e);
    step(ld, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    ld.rdy = 1'b1; ld.rdata = 16'h9999;
    step(ld, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    s = nop; s.rst = 1'b0;
    step(s, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));
    step(nop, ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000));

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
